// File: rtl/kmp_pkg.sv
// Shared types and sizing helpers for the kmp4 stream feeder.
package kmp_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

  // Counters must hold the value STRING_SIZE itself without wrapping.
  function automatic int cnt_width(input int string_size);
    return $clog2(string_size + 1);
  endfunction

endpackage

// File: rtl/kmp_byte_fifo.sv
// Byte FIFO with first-word-fall-through read and a synchronous flush.
module kmp_byte_fifo
  import kmp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  push,
  input  logic  pop,
  input  byte_t wdata,
  output byte_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  byte_t         mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/kmp_stream_feeder.sv
// Buffers a host byte stream and re-emits exactly STRING_SIZE bytes per job toward kmp4.
module kmp_stream_feeder
  import kmp_pkg::*;
#(
  parameter int STRING_SIZE = 2241,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  byte_t       s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output byte_t       m_data,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic [31:0] sent_count
);

  localparam int            CW       = cnt_width(STRING_SIZE);
  localparam logic [CW-1:0] LEN      = CW'(STRING_SIZE);
  localparam logic [CW-1:0] LAST_IDX = CW'(STRING_SIZE - 1);

  feeder_state_t state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic  fifo_clear, fifo_full, fifo_empty;
  logic  s_xfer, m_xfer;
  byte_t fifo_rdata;

  assign fifo_clear = (state_q == IDLE) && start;
  assign s_xfer     = s_valid && s_ready;
  assign m_xfer     = m_valid && m_ready;

  kmp_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (s_xfer),
    .pop   (m_xfer),
    .wdata (s_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (m_xfer && m_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; m_data is gated so it reads zero whenever nothing is offered.
  always_comb begin
    busy       = (state_q == STREAM);
    done       = (state_q == DONE);
    s_ready    = busy && !fifo_full && (in_cnt_q < LEN);
    m_valid    = busy && !fifo_empty;
    m_last     = m_valid && (out_cnt_q == LAST_IDX);
    m_data     = m_valid ? fifo_rdata : '0;
    sent_count = 32'(out_cnt_q);
  end

  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (fifo_clear) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (s_xfer) in_cnt_d  = in_cnt_q + CW'(1);
      if (m_xfer) out_cnt_d = out_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_kmp_stream_feeder.sv
// Directed scoreboard bench for kmp_stream_feeder with STRING_SIZE=8, FIFO_DEPTH=4.
module tb_kmp_stream_feeder;
  import kmp_pkg::*;

  localparam int SS = 8;

  typedef struct packed {
    byte_t data;
    logic  last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready, m_valid, m_ready, m_last, busy, done;
  byte_t       s_data, m_data;
  logic [31:0] sent_count;

  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    done_seen = 0;
  int    accepted = 0;
  logic  held_valid = 1'b0;
  byte_t held_data = '0;

  kmp_stream_feeder #(.STRING_SIZE(SS), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, when inputs driven after the rising edge are settled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_valid = 1'b0;
    end else begin
      if (done) done_seen++;
      if (s_valid && s_ready) accepted++;
      if (held_valid) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {24'd0, m_data}, {24'd0, held_data});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got 0x%0h, expected no transfer at %0t", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'd0, m_data}, {24'd0, e.data});
          check("out_last", {31'd0, m_last}, {31'd0, e.last});
        end
      end
      held_valid = m_valid && !m_ready;
      held_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_job(input byte_t base, input int n, input int total);
    for (int i = 0; i < n; i++) exp_q.push_back('{data: byte_t'(base + i), last: (i == total - 1)});
  endtask

  task automatic send(input byte_t b);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("send_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 50) begin
      tick();
      cyc++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc, acc0, d0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    tick(); tick();
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sent_count", sent_count, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_s_ready", {31'd0, s_ready}, 32'd0);

    // Basic job: 0x41..0x48 back-to-back.
    do_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_s_ready", {31'd0, s_ready}, 32'd1);
    expect_job(8'h41, SS, SS);
    send(8'h41);
    check("latency_valid", {31'd0, m_valid}, 32'd1);
    check("latency_data", {24'd0, m_data}, 32'h41);
    for (int i = 1; i < SS; i++) send(byte_t'(8'h41 + i));
    wait_done(cyc);
    check("done_latency", cyc, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("basic_sent", sent_count, 32'd8);
    check("basic_drained", exp_q.size(), 32'd0);
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);
    check("sent_hold", sent_count, 32'd8);

    // Backpressure: m_ready low for 10 cycles right after start.
    m_ready = 1'b0;
    acc0 = accepted;
    do_start();
    expect_job(8'h51, SS, SS);
    fork
      begin
        for (int i = 0; i < SS; i++) send(byte_t'(8'h51 + i));
      end
      begin
        repeat (6) tick();
        check("bp_s_ready", {31'd0, s_ready}, 32'd0);
        check("bp_fill", accepted - acc0, 32'd4);
        check("bp_head", {24'd0, m_data}, 32'h51);
        repeat (4) tick();
        m_ready = 1'b1;
      end
    join
    wait_done(cyc);
    check("bp_sent", sent_count, 32'd8);
    check("bp_drained", exp_q.size(), 32'd0);
    tick();

    // Overrun guard: s_valid held for 12 cycles.
    acc0 = accepted;
    d0   = done_seen;
    do_start();
    expect_job(8'h10, SS, SS);
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_data  = byte_t'(8'h10 + (accepted - acc0));
      tick();
    end
    s_valid = 1'b0;
    check("ovr_accepted", accepted - acc0, 32'd8);
    check("ovr_s_ready", {31'd0, s_ready}, 32'd0);
    check("ovr_done_once", done_seen - d0, 32'd1);
    check("ovr_sent", sent_count, 32'd8);
    check("ovr_drained", exp_q.size(), 32'd0);

    // Start during STREAM is ignored.
    do_start();
    expect_job(8'h20, SS, SS);
    for (int i = 0; i < 3; i++) send(byte_t'(8'h20 + i));
    do_start();
    check("ign_busy", {31'd0, busy}, 32'd1);
    check("ign_sent", sent_count, 32'd3);
    for (int i = 3; i < SS; i++) send(byte_t'(8'h20 + i));
    wait_done(cyc);
    check("ign_total", sent_count, 32'd8);
    tick();

    // Restart, then reset after 3 outputs.
    do_start();
    check("restart_sent", sent_count, 32'd0);
    expect_job(8'h61, 3, SS);
    for (int i = 0; i < 4; i++) send(byte_t'(8'h61 + i));
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_m_data", {24'd0, m_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_sent", sent_count, 32'd0);
    check("mid_rst_outputs", exp_q.size(), 32'd0);
    rst = 1'b0;
    m_ready = 1'b1;
    d0 = done_seen;
    repeat (3) tick();
    check("mid_rst_no_done", done_seen - d0, 32'd0);
    do_start();
    check("post_rst_empty", {31'd0, m_valid}, 32'd0);
    expect_job(8'h71, SS, SS);
    for (int i = 0; i < SS; i++) send(byte_t'(8'h71 + i));
    wait_done(cyc);
    check("post_rst_sent", sent_count, 32'd8);
    check("post_rst_drained", exp_q.size(), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kmp_stream_feeder.md
# kmp_stream_feeder

Upstream feeder for the `kmp4` matcher. It accepts a host byte stream, buffers it in a small FIFO, and re-emits exactly `STRING_SIZE` bytes per job on a valid/ready stream with `last` on the final byte, so it drives `kmp4`'s `in_valid`/`in_ready`/`in_data`/`in_last` directly. It also decouples host-side stalls from the matcher and reports job completion and the byte count.

## Interface
- `STRING_SIZE`, default 2241: bytes per job; the job ends after this many output transfers; must be ≥ 1.
- `FIFO_DEPTH`, default 16: buffer entries; power of two, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that arms a job; honoured only in IDLE.
- `s_valid` in 1: host byte valid.
- `s_ready` out 1: feeder accepts a host byte.
- `s_data` in 8: host byte.
- `m_valid` out 1: byte valid toward `kmp4` (`in_valid`).
- `m_ready` in 1: `kmp4` `in_ready`.
- `m_data` out 8: byte to `kmp4` (`in_data`).
- `m_last` out 1: final byte of the job (`in_last`).
- `busy` out 1: a job is in progress (STREAM).
- `done` out 1: one-cycle pulse after the last output transfer.
- `sent_count` out 32: output transfers in the current or last job.

## Operation
- FSM states:
  - **IDLE.** `start` moves to STREAM. Same edge clears `in_cnt`, `out_cnt`, `sent_count` and flushes the FIFO.
  - **STREAM.** Moves to DONE on the edge of the output transfer with `m_last`=1.
  - **DONE.** Lasts exactly one cycle with `done`=1, then goes to IDLE.
- `start` in STREAM or DONE is ignored.
- Input side:
  - `s_ready = (state==STREAM) && !full && (in_cnt < STRING_SIZE)`.
  - A transfer happens when `s_valid && s_ready`; it pushes `s_data` and increments `in_cnt`.
  - Bytes beyond `STRING_SIZE` are not accepted; `s_ready` stays 0 until the next job.
- Output side:
  - `m_valid = (state==STREAM) && !empty`. `m_data` is the FIFO head (first-word-fall-through).
  - A transfer happens when `m_valid && m_ready`; it pops the FIFO and increments `out_cnt` and `sent_count`.
  - `m_last = m_valid && (out_cnt == STRING_SIZE-1)`.
- Once `m_valid` is raised, it and `m_data` stay stable until accepted.
- Width rules:
  - `in_cnt` and `out_cnt` are `$clog2(STRING_SIZE+1)` bits and never wrap within a job.
  - `sent_count` is zero-extended to 32 bits and holds its value after `done` until the next `start`.
- FIFO behaviour:
  - Push and pop in the same cycle leave the occupancy unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - When full, `s_ready`=0; there is no bypass.
  - Pop on empty cannot occur, because `m_valid` gates it.
- Reset, including mid-job: state goes to IDLE, the FIFO empties, all counters clear, and any partial job is discarded with no `done`.

## Timing
- Reset values of all outputs are 0: `s_ready`, `m_valid`, `m_data`, `m_last`, `busy`, `done`, `sent_count`.
- `busy` and `s_ready` can first be 1 on the cycle after `start` is sampled.
- Input-to-output latency is 1 cycle: a byte accepted at edge N is on `m_data` with `m_valid`=1 from N+1.
- Sustained throughput is 1 byte/cycle when `s_valid` and `m_ready` are held high.
- `done` is high in the cycle after the last output transfer. `busy` falls in that same cycle.
- A new `start` is accepted from the first IDLE cycle, i.e. 2 cycles after the last transfer.

## Structure
- Package `kmp_pkg`:
  - `byte_t` (`logic [7:0]`).
  - `feeder_state_t` enum {IDLE, STREAM, DONE}.
  - Counter width as a function of `STRING_SIZE`.
- One sub-module, `kmp_byte_fifo`:
  - Parameter `DEPTH`.
  - Ports: push, pop, `wdata`, `rdata`, `full`, `empty`, synchronous `clear`.
  - Registered storage with FWFT read.
- Top-level holds the FSM, both counters and the handshake glue: about 200 RTL lines total.

## Test plan
- **Basic job.** `STRING_SIZE`=8, `FIFO_DEPTH`=4, `start`, bytes 0x41..0x48 sent back-to-back with `m_ready`=1.
  - Expect 8 outputs in order, `m_last` only on 0x48.
  - Expect `done` one cycle later and `sent_count`=8.
- **Backpressure.** `m_ready` low for 10 cycles mid-job.
  - Expect FIFO fill: `s_ready`=0 after 4 buffered bytes.
  - Expect `m_data` stable while stalled, and no byte lost or duplicated.
- **Overrun guard.** Host holds `s_valid`=1 for 12 bytes with `STRING_SIZE`=8.
  - Expect only 8 accepted, `s_ready`=0 thereafter, and `m_last` on the 8th.
- **Ignored start / restart.**
  - `start` pulsed during STREAM has no effect.
  - A second `start` after `done` runs a new job with `sent_count` restarting at 0.
- **Reset mid-job.** `rst` after 3 outputs.
  - Expect all outputs 0 next cycle, no `done`, and the FIFO empty.
  - A following job streams cleanly.
- **Integration.** Default `STRING_SIZE`=2241 feeding `kmp4` with pattern "ABCD" and the tightly packed "ABCD" string.
  - Expect `kmp4` `n_matches`=560 and `sent_count`=2241.
